// File: rtl/hazard5_ahbl_arb2.sv
// hazard5_ahbl_arb2: two-master to one-slave AHB-Lite arbiter (single NONSEQ/IDLE transfers).
//
// Lets a second master (m1, e.g. debug or DMA) share the core's bus (m0) onto
// one downstream slave port (s). A master whose address phase cannot go out
// this cycle has it captured in a private buffer. That master is then stalled
// through its own hready until the buffered transfer's data phase completes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mN_h* (N = 0,1)     upstream AHB-Lite master ports (address/control/wdata in,
//                       hready/hresp/hrdata out)
//   s_h*                downstream AHB-Lite slave port
//
// Optional feature macro: HAZARD5_ARB_RR_EN
//   defined   - contention is granted to the master that did not win last
//   undefined - fixed priority, m0 wins contention
module hazard5_ahbl_arb2 #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [1:0]        m0_htrans,
    input  logic [2:0]        m0_hsize,
    input  logic [3:0]        m0_hprot,
    input  logic [W_DATA-1:0] m0_hwdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    output logic [W_DATA-1:0] m0_hrdata,
    input  logic [W_ADDR-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [1:0]        m1_htrans,
    input  logic [2:0]        m1_hsize,
    input  logic [3:0]        m1_hprot,
    input  logic [W_DATA-1:0] m1_hwdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [W_DATA-1:0] m1_hrdata,
    output logic [W_ADDR-1:0] s_haddr,
    output logic              s_hwrite,
    output logic [1:0]        s_htrans,
    output logic [2:0]        s_hsize,
    output logic [3:0]        s_hprot,
    output logic [W_DATA-1:0] s_hwdata,
    input  logic              s_hready,
    input  logic              s_hresp,
    input  logic [W_DATA-1:0] s_hrdata
);
    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [3:0]        prot;
    } addr_ph_t;

    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

    addr_ph_t   in_ph [2];
    addr_ph_t   buf_q [2];
    addr_ph_t   buf_d [2];
    addr_ph_t   s_ph;
    logic [1:0] in_nseq, hready, live, req, pend_q, pend_d;
    owner_e     gnt_d, gnt_q, dph_d, dph_q;
    logic       hold_d, hold_q, accept, sel, pri1;
`ifdef HAZARD5_ARB_RR_EN
    logic       last_d, last_q;
`endif
    logic       unused;

    assign in_ph[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_hprot};
    assign in_ph[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_hprot};
    assign in_nseq  = {m1_htrans[1], m0_htrans[1]};
    // Only NONSEQ/IDLE are handled, so htrans[0] carries no information
    assign unused   = ^{m0_htrans[0], m1_htrans[0]};

    always_comb begin
        hready[0] = dph_q == OWN_M0 ? s_hready : !pend_q[0];
        hready[1] = dph_q == OWN_M1 ? s_hready : !pend_q[1];
        live      = in_nseq & hready;
        req       = pend_q | live;
`ifdef HAZARD5_ARB_RR_EN
        // last_q = 1 means m1 won last, so m0 gets the next contended slot
        pri1      = !last_q;
`else
        pri1      = 1'b0;
`endif
        // A stalled address phase must not change, so keep the previous grant
        gnt_d     = hold_q ? gnt_q :
                    (req[0] && !(req[1] && pri1)) ? OWN_M0 :
                    req[1] ? OWN_M1 : OWN_NONE;
        sel       = gnt_d == OWN_M1;
        s_ph      = gnt_d == OWN_NONE ? '0 : pend_q[sel] ? buf_q[sel] : in_ph[sel];
        accept    = gnt_d != OWN_NONE && s_hready;
        for (int i = 0; i < 2; i++) begin
            // A live request that does not leave this cycle is captured for reissue
            pend_d[i] = accept && sel == i[0] ? 1'b0 : live[i] | pend_q[i];
            buf_d[i]  = live[i] && !(accept && sel == i[0]) ? in_ph[i] : buf_q[i];
        end
        dph_d     = s_hready ? gnt_d : dph_q;
        hold_d    = gnt_d != OWN_NONE && !s_hready;
`ifdef HAZARD5_ARB_RR_EN
        last_d    = accept ? sel : last_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            gnt_q    <= OWN_NONE;
            dph_q    <= OWN_NONE;
            hold_q   <= 1'b0;
`ifdef HAZARD5_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            pend_q   <= pend_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            gnt_q    <= gnt_d;
            dph_q    <= dph_d;
            hold_q   <= hold_d;
`ifdef HAZARD5_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign s_htrans  = gnt_d == OWN_NONE ? 2'b00 : 2'b10;
    assign s_haddr   = s_ph.addr;
    assign s_hwrite  = s_ph.write;
    assign s_hsize   = s_ph.size;
    assign s_hprot   = s_ph.prot;
    assign s_hwdata  = dph_q == OWN_M0 ? m0_hwdata : dph_q == OWN_M1 ? m1_hwdata : '0;
    assign m0_hready = hready[0];
    assign m1_hready = hready[1];
    assign m0_hresp  = dph_q == OWN_M0 && s_hresp;
    assign m1_hresp  = dph_q == OWN_M1 && s_hresp;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
endmodule

// File: tb/tb_hazard5_ahbl_arb2.sv
// tb_hazard5_ahbl_arb2: directed literal checks plus randomized traffic against a transaction-level model.
module tb_hazard5_ahbl_arb2;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
    } xfer_t;

`ifdef HAZARD5_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr [2];
    logic        hwrite [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic [3:0]  hprot [2];
    logic [31:0] hwdata [2];
    logic        m0_hready, m0_hresp, m1_hready, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic [31:0] s_haddr, s_hwdata;
    logic        s_hwrite;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [3:0]  s_hprot;
    logic        s_hready = 1'b1;
    logic        s_hresp = 1'b0;
    logic [31:0] s_hrdata = '0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard5_ahbl_arb2 #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_haddr(haddr[0]), .m0_hwrite(hwrite[0]), .m0_htrans(htrans[0]),
        .m0_hsize(hsize[0]), .m0_hprot(hprot[0]), .m0_hwdata(hwdata[0]),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_haddr(haddr[1]), .m1_hwrite(hwrite[1]), .m1_htrans(htrans[1]),
        .m1_hsize(hsize[1]), .m1_hprot(hprot[1]), .m1_hwdata(hwdata[1]),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans),
        .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        for (int n = 0; n < 2; n++) begin
            htrans[n] = 2'b00;
            haddr[n]  = '0;
            hwrite[n] = 1'b0;
            hsize[n]  = 3'd2;
            hprot[n]  = 4'h3;
            hwdata[n] = '0;
        end
    endtask

    task automatic req(input int n, input logic [31:0] a, input logic w);
        htrans[n] = 2'b10;
        haddr[n]  = a;
        hwrite[n] = w;
    endtask

    // Transaction-level model: each master has at most one parked address
    // phase; the slave-side grant is chosen from who wants the bus.
    bit    mp [2];
    xfer_t ms [2];
    int    mown, mgprev, mlast;
    bit    mhold;
    int    cap_cnt, acc_cnt;

    initial begin
        bit    hr [2];
        bit    live [2];
        bit    rq [2];
        xfer_t cur [2];
        xfer_t ex;
        int    g;
        idle_masters();
        tick();
        tick();
        chk("rst_s_htrans", 64'(s_htrans), 64'd0);
        chk("rst_s_haddr", 64'(s_haddr), 64'd0);
        chk("rst_m0_hready", 64'(m0_hready), 64'd1);
        chk("rst_m1_hready", 64'(m1_hready), 64'd1);
        chk("rst_m0_hresp", 64'(m0_hresp), 64'd0);
        chk("rst_m1_hresp", 64'(m1_hresp), 64'd0);
        rst_n = 1'b1;
        tick();
        // m0 alone: zero-wait issue
        req(0, 32'h1000, 1'b0);
        #1;
        chk("solo_htrans", 64'(s_htrans), 64'd2);
        chk("solo_haddr", 64'(s_haddr), 64'h1000);
        tick();
        idle_masters();
        s_hrdata = 32'hdeadbeef;
        #1;
        chk("solo_hrdata", 64'(m0_hrdata), 64'hdeadbeef);
        chk("solo_m0_hready", 64'(m0_hready), 64'd1);
        chk("solo_m1_hready", 64'(m1_hready), 64'd1);
        tick();
        // Contention: m0 write wins, m1 read issued next cycle from its buffer
        req(0, 32'h2000, 1'b1);
        req(1, 32'h3000, 1'b0);
        #1;
        chk("cont_haddr0", 64'(s_haddr), 64'h2000);
        chk("cont_hwrite0", 64'(s_hwrite), 64'd1);
        chk("cont_m1_hready0", 64'(m1_hready), 64'd1);
        tick();
        idle_masters();
        hwdata[0] = 32'h11112222;
        hwdata[1] = 32'h77777777;
        #1;
        chk("cont_haddr1", 64'(s_haddr), 64'h3000);
        chk("cont_htrans1", 64'(s_htrans), 64'd2);
        chk("cont_hwrite1", 64'(s_hwrite), 64'd0);
        chk("cont_hwdata1", 64'(s_hwdata), 64'h11112222);
        chk("cont_m1_hready1", 64'(m1_hready), 64'd0);
        chk("cont_m0_hready1", 64'(m0_hready), 64'd1);
        tick();
        chk("cont_m1_hready2", 64'(m1_hready), 64'd1);
        chk("cont_hwdata2", 64'(s_hwdata), 64'h77777777);
        chk("cont_htrans2", 64'(s_htrans), 64'd0);
        tick();
        idle_masters();
        // Two wait states on m0's address phase while m1 also requests
        s_hready = 1'b0;
        req(0, 32'h4000, 1'b0);
        req(1, 32'h5000, 1'b0);
        #1;
        chk("ws_haddr0", 64'(s_haddr), 64'h4000);
        tick();
        idle_masters();
        #1;
        chk("ws_haddr1", 64'(s_haddr), 64'h4000);
        chk("ws_m0_hready1", 64'(m0_hready), 64'd0);
        chk("ws_m1_hready1", 64'(m1_hready), 64'd0);
        tick();
        s_hready = 1'b1;
        #1;
        chk("ws_haddr2", 64'(s_haddr), 64'h4000);
        chk("ws_htrans2", 64'(s_htrans), 64'd2);
        tick();
        chk("ws_haddr3", 64'(s_haddr), 64'h5000);
        chk("ws_m0_hready3", 64'(m0_hready), 64'd1);
        chk("ws_m1_hready3", 64'(m1_hready), 64'd0);
        tick();
        chk("ws_htrans4", 64'(s_htrans), 64'd0);
        chk("ws_m1_hready4", 64'(m1_hready), 64'd1);
        tick();
        // Two-cycle ERROR on an m1 transfer
        req(1, 32'h6000, 1'b0);
        #1;
        chk("err_haddr", 64'(s_haddr), 64'h6000);
        tick();
        idle_masters();
        s_hresp = 1'b1;
        s_hready = 1'b0;
        #1;
        chk("err_m1_hresp0", 64'(m1_hresp), 64'd1);
        chk("err_m0_hresp0", 64'(m0_hresp), 64'd0);
        chk("err_m1_hready0", 64'(m1_hready), 64'd0);
        tick();
        s_hready = 1'b1;
        #1;
        chk("err_m1_hresp1", 64'(m1_hresp), 64'd1);
        chk("err_m0_hresp1", 64'(m0_hresp), 64'd0);
        chk("err_m1_hready1", 64'(m1_hready), 64'd1);
        tick();
        s_hresp = 1'b0;
        // Four back-to-back contended pairs: m0,m1 alternate in both builds
        for (int k = 0; k < 4; k++) begin
            tick();
            req(0, 32'h100 + 32'(k * 16), 1'b0);
            req(1, 32'h200 + 32'(k * 16), 1'b0);
            #1;
            chk("pair_first", 64'(s_haddr), 64'(32'h100 + 32'(k * 16)));
            tick();
            idle_masters();
            #1;
            chk("pair_second", 64'(s_haddr), 64'(32'h200 + 32'(k * 16)));
        end
        // Reset while m1 is parked: its buffered address must never go out
        tick();
        req(0, 32'h7000, 1'b0);
        req(1, 32'h8000, 1'b0);
        tick();
        idle_masters();
        s_hready = 1'b0;
        #1;
        chk("rstp_haddr", 64'(s_haddr), 64'h8000);
        rst_n = 1'b0;
        #1;
        chk("rstp_htrans0", 64'(s_htrans), 64'd0);
        chk("rstp_m1_hready0", 64'(m1_hready), 64'd1);
        tick();
        rst_n = 1'b1;
        s_hready = 1'b1;
        #1;
        chk("rstp_htrans1", 64'(s_htrans), 64'd0);
        chk("rstp_m1_hready1", 64'(m1_hready), 64'd1);
        tick();
        // Randomized traffic against the model
        mp[0] = 1'b0;
        mp[1] = 1'b0;
        mown = -1;
        mgprev = -1;
        mlast = 1;
        mhold = 1'b0;
        cap_cnt = 0;
        acc_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                htrans[n] = $urandom_range(0, 1) != 0 ? 2'b10 : 2'b00;
                haddr[n]  = $urandom;
                hwrite[n] = 1'($urandom_range(0, 1));
                hsize[n]  = 3'($urandom_range(0, 2));
                hprot[n]  = 4'($urandom_range(0, 15));
                hwdata[n] = $urandom;
                cur[n]    = {haddr[n], hwrite[n], hsize[n], hprot[n]};
            end
            s_hready = $urandom_range(0, 3) != 0;
            s_hresp  = $urandom_range(0, 7) == 0;
            s_hrdata = $urandom;
            #1;
            for (int n = 0; n < 2; n++) begin
                hr[n]   = mown == n ? s_hready : !mp[n];
                live[n] = htrans[n][1] && hr[n];
                rq[n]   = mp[n] || live[n];
            end
            if (mhold) g = mgprev;
            else if (rq[0] && rq[1]) g = (RR && mlast == 0) ? 1 : 0;
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            else g = -1;
            ex = g < 0 ? '0 : (mp[g] ? ms[g] : cur[g]);
            chk("rnd_s_htrans", 64'(s_htrans), g < 0 ? 64'd0 : 64'd2);
            chk("rnd_s_phase", 64'({s_haddr, s_hwrite, s_hsize, s_hprot}), 64'(ex));
            chk("rnd_s_hwdata", 64'(s_hwdata), mown < 0 ? 64'd0 : 64'(hwdata[mown]));
            chk("rnd_m0_hready", 64'(m0_hready), 64'(hr[0]));
            chk("rnd_m1_hready", 64'(m1_hready), 64'(hr[1]));
            chk("rnd_m0_hresp", 64'(m0_hresp), 64'(mown == 0 && s_hresp));
            chk("rnd_m1_hresp", 64'(m1_hresp), 64'(mown == 1 && s_hresp));
            chk("rnd_hrdata", 64'({m0_hrdata, m1_hrdata}), {s_hrdata, s_hrdata});
            if (s_htrans[1] && s_hready) acc_cnt++;
            for (int n = 0; n < 2; n++) begin
                if (live[n]) cap_cnt++;
                if (g == n && s_hready) mp[n] = 1'b0;
                else if (live[n]) begin
                    mp[n] = 1'b1;
                    ms[n] = cur[n];
                end
            end
            if (g >= 0 && s_hready) mlast = g;
            if (s_hready) mown = g;
            mhold = g >= 0 && !s_hready;
            mgprev = g;
        end
        // Drain: every captured request must reach the slave exactly once
        tick();
        idle_masters();
        s_hready = 1'b1;
        s_hresp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_htrans[1] && s_hready) acc_cnt++;
            tick();
        end
        chk("conservation", 64'(acc_cnt), 64'(cap_cnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard5_ahbl_arb2.md
Name: hazard5_ahbl_arb2

Overview:
- Two-master to one-slave AHB-Lite arbiter.
- Lets a second bus master (debug module or DMA, port m1) share the single-ported core's AHB-Lite master bus (port m0) onto one downstream slave port s.
- The losing master's address phase is captured in a per-port buffer, and that master is stalled via its own hready until the buffered transfer completes.
- Only NONSEQ/IDLE single transfers are handled, matching the core's single-beat usage.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- mN_haddr  in  W_ADDR  master N address (N = 0,1; every mN_* port exists for both)
- mN_hwrite  in  1  master N write
- mN_htrans  in  2  master N transfer type
- mN_hsize  in  3  master N size
- mN_hprot  in  4  master N protection
- mN_hwdata  in  W_DATA  master N write data
- mN_hready  out  1  ready to master N
- mN_hresp  out  1  response to master N
- mN_hrdata  out  W_DATA  read data to master N
- s_haddr  out  W_ADDR  slave address
- s_hwrite  out  1  slave write
- s_htrans  out  2  slave transfer type
- s_hsize  out  3  slave size
- s_hprot  out  4  slave protection
- s_hwdata  out  W_DATA  slave write data
- s_hready  in  1  slave ready
- s_hresp  in  1  slave response
- s_hrdata  in  W_DATA  slave read data

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - s_htrans=IDLE; s_haddr/s_hsize/s_hprot/s_hwrite=0.
  - Both pend flags clear; dph owner=none; hold=0.
  - mN_hready=1, mN_hresp=0.
- Requests:
  - Live request N = mN_htrans[1] && mN_hready.
  - Effective request N = pend_N || live_N.
  - While pend_N is set, the buffer supplies the fields and live inputs are ignored.
- Hold:
  - hold register <= s_htrans[1] && !s_hready.
  - While hold=1, the grant equals the previous cycle's grant, so s_* address fields stay stable.
- Grant (combinational, when not held):
  - Only one effective request: grant it.
  - Both: m0 wins, unless the optional feature is enabled.
  - Neither: s_htrans=IDLE, fields 0.
- Issue/accept: the granted transfer is accepted on a cycle with s_hready=1. On acceptance:
  - pend_winner clears.
  - dph owner <= winner; dph owner updates only when s_hready=1.
- Buffering:
  - A master with a live request that is not granted, or is granted but not accepted, loads haddr/hwrite/hsize/hprot into its buffer and sets pend that same edge.
  - Zero-wait issue is required when uncontended: no added address-phase latency.
- mN_hready:
  - = s_hready when dph owner==N.
  - Else 0 while pend_N is set.
  - Else 1.
  - A pending master therefore sees its data phase stretched until its buffered transfer's slave data phase completes.
- mN_hresp = s_hresp when dph owner==N, else 0. Both cycles of an ERROR response are passed through unchanged.
- mN_hrdata = s_hrdata for both masters. s_hwdata = hwdata of the dph owner, 0 if none.
- Buffered transfers are always issued. A master cannot cancel a buffered transfer after an ERROR on its previous transfer.
- Simultaneous accept of one master and a new live request from the other: the winner goes out, the other is buffered. No transfer is ever lost or duplicated.
- Reset asserted mid-transfer: all state clears immediately and pending transfers are discarded.

Optional Feature:
- HAZARD5_ARB_RR_EN:
  - Defined: adds a 1-bit last-winner register, reset to m1. On contention the master that did not win last is granted. Last-winner updates on every accepted transfer.
  - Undefined: fixed priority, m0 always wins contention, and the register is absent.

Test Plan:
- m0 alone, NONSEQ read 0x1000 with s_hready=1 -> s_htrans=NSEQ same cycle, s_haddr=0x1000; next cycle m0_hrdata=s_hrdata, m0_hready=1, m1_hready=1.
- Both NONSEQ same cycle (m0 0x2000 write, m1 0x3000 read), feature off -> 0x2000 issued first, 0x3000 issued next cycle from buffer; m1_hready low for exactly 1 extra cycle; s_hwdata=m0_hwdata in 0x2000 data phase.
- Slave inserts 2 wait states on m0's address phase while m1 requests -> s_haddr held at m0's address for all 3 cycles, m1 buffered and issued after acceptance.
- ERROR response (s_hresp=1, s_hready 0 then 1) on m1 transfer -> m1_hresp=1 for both cycles, m0_hresp=0 throughout.
- HAZARD5_ARB_RR_EN defined, 4 back-to-back contended pairs -> grant order m0,m1,m0,m1,m0,m1,m0,m1.
- rst_n low during a pending m1 transfer -> next cycle s_htrans=IDLE, m1_hready=1, buffered address never issued.
